yuv_frame_queue: RTL and testbench
==================================

# yuv_frame_queue

Single-clock, parametrised queue of planar YUV frame descriptors between the FMV decoder's frame-completion logic and the display fetch. It generalises the earlier fixed 16-entry frame address FIFO with a configurable depth, occupancy and threshold outputs, sticky error flags, and a skip operation. Skip lets display catch up by discarding stale decoded frames in one cycle.

## Interface
- DEPTH, 16, number of entries; power of two, minimum 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL; range 1..DEPTH.
- LW, $clog2(DEPTH)+1, level width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush.
- wdata  in  planar_yuv_s  frame descriptor to enqueue.
- we  in  1  enqueue request.
- strobe  in  1  pop head, advancing to next frame.
- skip  in  1  drop all entries except the newest.
- q  out  planar_yuv_s  current head descriptor, registered.
- valid  out  1  q holds a queued entry.
- level  out  LW  entries held, 0..DEPTH.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AF_LEVEL.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: strobe issued while empty.

## Operation
- Storage is a DEPTH-entry array with wrapping read and write pointers of $clog2(DEPTH) bits. level is kept as an explicit counter, not derived from pointer difference.
- Priority per cycle: reset_n, then clear, then skip, then strobe/we.
- clear:
  - level=0 and pointers=0.
  - overflow and underflow cleared; valid=0.
  - q holds its last value; we in the same cycle is ignored.
- skip, level>=2, no we: read pointer moves to newest entry; level=1.
- skip with we: queue becomes exactly {wdata}; level=1.
- skip with level<=1 and no we: no effect. strobe is ignored while skip is high.
- strobe, level>0: head popped.
- strobe, level==0: ignored; underflow set.
- we, not full: wdata stored at write pointer.
- we when full with strobe: accepted; level unchanged.
- we when full without strobe: data discarded; overflow set; state otherwise unchanged.
- we and strobe both accepted: level unchanged.
- Pointers wrap modulo DEPTH. level never exceeds DEPTH and never goes below 0.
- Empty queue: valid=0 and q keeps the last frame shown, so display repeats it.

## Timing
- Reset values: q=0, valid=0, level=0, full=0, almost_full=0, overflow=0, underflow=0; pointers 0.
- All outputs are registered and reflect state after the triggering edge.
- Write into empty queue at edge N: valid=1 and q=wdata from edge N. No extra read latency; bypass is required.
- Pop at edge N: q shows the next entry from edge N. If the queue is now empty, valid=0 and q is unchanged.
- Simultaneous we+strobe with level==1: q=wdata after the edge, valid stays 1.
- reset_n deassertion is synchronised externally. Assertion mid-operation clears everything immediately.

## Configuration
- YUV_FRAME_QUEUE_STATS_EN defined:
  - Adds output dropped_cnt [15:0]: frames discarded by skip or rejected by overflow. A skip from level L adds L-1, or L if it also accepted we. Saturates at 16'hFFFF.
  - Adds output repeat_cnt [15:0]: cycles with strobe while empty. Saturates at 16'hFFFF.
  - Both counters reset by reset_n and by clear.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- planar_yuv_s stays in the shared util package.
- A frame_queue_pkg holds:
  - the level-width helper function;
  - the stats counter width constant (16).
- No sub-module: pointers, level counter and storage array are inline; storage is inferred as distributed RAM/registers.

## Test plan
- Reset, then write A: after the edge valid=1, q=A, level=1. strobe: valid=0, q=A held, level=0.
- DEPTH=4: write 4 frames, full=1. Fifth write without strobe: overflow=1, level=4, head unchanged. Fifth write with strobe: accepted, level=4.
- strobe on empty: underflow=1, level stays 0. With stats enabled, repeat_cnt=1.
- Write A,B,C then skip: level=1, q=C. Next test: skip with we=D from level 3: level=1, q=D, dropped_cnt=3.
- Wrap: 40 interleaved write/pop pairs at DEPTH=4: FIFO order preserved, level never exceeds 4.
- Assert reset_n low mid-stream with level=3: all outputs return to reset values without waiting for a clk edge.

Source files
------------

// File: rtl/frame_queue_pkg.sv
// Sizing helpers and constants for yuv_frame_queue.
package frame_queue_pkg;

  localparam int STAT_W = 16;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/util_pkg.sv
// Shared utility types used across the decoder and display blocks.
package util_pkg;

  typedef struct packed {
    logic [31:0] y_addr;
    logic [31:0] u_addr;
    logic [31:0] v_addr;
  } planar_yuv_s;

endpackage

// File: rtl/yuv_frame_queue.sv
// Queue of planar YUV frame descriptors from decoder completion to display fetch.
// Optional YUV_FRAME_QUEUE_STATS_EN adds dropped_cnt / repeat_cnt statistics outputs.
module yuv_frame_queue
  import util_pkg::*, frame_queue_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int LW      = level_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  planar_yuv_s       wdata,
  input  logic              we,
  input  logic              strobe,
  input  logic              skip,
  output planar_yuv_s       q,
  output logic              valid,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
`ifdef YUV_FRAME_QUEUE_STATS_EN
  ,
  output logic [STAT_W-1:0] dropped_cnt,
  output logic [STAT_W-1:0] repeat_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);

  planar_yuv_s   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_n, wr_n, newest;
  logic [LW-1:0] level_n;
  logic          do_push, do_pop, ovf_set, udf_set, valid_n;
  planar_yuv_s   q_n;

  assign newest = wr_ptr - 1'b1;

  always_comb begin
    rd_n    = rd_ptr;
    wr_n    = wr_ptr;
    level_n = level;
    do_push = 1'b0;
    do_pop  = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    q_n     = q;
    valid_n = valid;
    if (skip) begin
      // strobe is ignored while skip is high
      if (we) begin
        do_push = 1'b1;
        rd_n    = wr_ptr;
        wr_n    = wr_ptr + 1'b1;
        level_n = LW'(1);
        q_n     = wdata;
        valid_n = 1'b1;
      end else if (level >= LW'(2)) begin
        rd_n    = newest;
        level_n = LW'(1);
        q_n     = mem[newest];
        valid_n = 1'b1;
      end
    end else begin
      do_pop  = strobe && (level != '0);
      do_push = we && (!full || do_pop);
      udf_set = strobe && (level == '0);
      ovf_set = we && !do_push;
      if (do_pop)  rd_n = rd_ptr + 1'b1;
      if (do_push) wr_n = wr_ptr + 1'b1;
      level_n = level + LW'(do_push) - LW'(do_pop);
      if (level_n == '0) begin
        valid_n = 1'b0;
      end else begin
        valid_n = 1'b1;
        // new head is the word being written this cycle when nothing else remains
        q_n = (do_push && (level == LW'(do_pop))) ? wdata : mem[rd_n];
      end
    end
  end

  always_ff @(posedge clk)
    if (do_push && !clear) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      q           <= '0;
      valid       <= 1'b0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (clear) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      valid       <= 1'b0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      rd_ptr      <= rd_n;
      wr_ptr      <= wr_n;
      level       <= level_n;
      q           <= q_n;
      valid       <= valid_n;
      full        <= (level_n == LW'(DEPTH));
      almost_full <= (level_n >= LW'(AF_LEVEL));
      overflow    <= overflow | ovf_set;
      underflow   <= underflow | udf_set;
    end
  end

`ifdef YUV_FRAME_QUEUE_STATS_EN
  logic [LW-1:0]   drop_inc;
  logic [STAT_W:0] drop_sum;

  always_comb begin
    drop_inc = '0;
    if (skip) begin
      if (we)                      drop_inc = level;
      else if (level >= LW'(2))    drop_inc = level - 1'b1;
    end else if (ovf_set) begin
      drop_inc = LW'(1);
    end
  end

  assign drop_sum = {1'b0, dropped_cnt} + (STAT_W+1)'(drop_inc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropped_cnt <= '0;
      repeat_cnt  <= '0;
    end else if (clear) begin
      dropped_cnt <= '0;
      repeat_cnt  <= '0;
    end else begin
      dropped_cnt <= drop_sum[STAT_W] ? '1 : drop_sum[STAT_W-1:0];
      if (udf_set && (repeat_cnt != '1)) repeat_cnt <= repeat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_yuv_frame_queue.sv
// Directed self-checking bench for yuv_frame_queue at DEPTH=4.
module tb_yuv_frame_queue;
  import util_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic        clk = 1'b0;
  logic        reset_n, clear, we, strobe, skip;
  planar_yuv_s wdata, q;
  logic        valid, full, almost_full, overflow, underflow;
  logic [LW-1:0] level;
`ifdef YUV_FRAME_QUEUE_STATS_EN
  logic [15:0] dropped_cnt, repeat_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  yuv_frame_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wdata(wdata), .we(we),
    .strobe(strobe), .skip(skip), .q(q), .valid(valid), .level(level),
    .full(full), .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
`ifdef YUV_FRAME_QUEUE_STATS_EN
    , .dropped_cnt(dropped_cnt), .repeat_cnt(repeat_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic planar_yuv_s fr(input int n);
    fr.y_addr = 32'h1000_0000 + n;
    fr.u_addr = 32'h2000_0000 + n;
    fr.v_addr = 32'h3000_0000 + n;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // apply one cycle of inputs, sample 1ns after the edge, then idle the inputs
  task automatic drive(input bit w, input planar_yuv_s d, input bit s, input bit sk, input bit c);
    we = w; wdata = d; strobe = s; skip = sk; clear = c;
    @(posedge clk); #1;
    we = 0; strobe = 0; skip = 0; clear = 0;
  endtask

  planar_yuv_s model[$];

  initial begin
    reset_n = 0; clear = 0; we = 0; strobe = 0; skip = 0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_valid", valid, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    reset_n = 1;

    // single write then pop
    drive(1, fr(1), 0, 0, 0);
    chk("wrA_valid", valid, 1);
    chk("wrA_q", q, fr(1));
    chk("wrA_level", level, 1);
    chk("wrA_af", almost_full, 0);
    drive(0, '0, 1, 0, 0);
    chk("popA_valid", valid, 0);
    chk("popA_q", q, fr(1));
    chk("popA_level", level, 0);

    // strobe on empty
    drive(0, '0, 1, 0, 0);
    chk("udf_flag", underflow, 1);
    chk("udf_level", level, 0);
`ifdef YUV_FRAME_QUEUE_STATS_EN
    chk("udf_repeat", repeat_cnt, 1);
`endif
    drive(0, '0, 0, 0, 1);
    chk("clr_udf", underflow, 0);

    // fill, overflow, write-with-pop when full
    for (int i = 2; i <= 5; i++) drive(1, fr(i), 0, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_af", almost_full, 1);
    chk("fill_level", level, 4);
    chk("fill_q", q, fr(2));
    drive(1, fr(6), 0, 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 4);
    chk("ovf_q", q, fr(2));
`ifdef YUV_FRAME_QUEUE_STATS_EN
    chk("ovf_dropped", dropped_cnt, 1);
`endif
    drive(1, fr(7), 1, 0, 0);
    chk("fullwp_level", level, 4);
    chk("fullwp_q", q, fr(3));
    chk("fullwp_full", full, 1);
    drive(0, '0, 0, 0, 1);
    chk("clr_level", level, 0);
    chk("clr_valid", valid, 0);
    chk("clr_q", q, fr(3));
    chk("clr_ovf", overflow, 0);
    chk("clr_full", full, 0);

    // skip without write
    for (int i = 10; i <= 12; i++) drive(1, fr(i), 0, 0, 0);
    drive(0, '0, 1, 1, 0);
    chk("skip_level", level, 1);
    chk("skip_q", q, fr(12));
    chk("skip_valid", valid, 1);
    chk("skip_udf", underflow, 0);
`ifdef YUV_FRAME_QUEUE_STATS_EN
    chk("skip_dropped", dropped_cnt, 2);
`endif
    drive(0, '0, 0, 0, 1);

    // skip with write
    for (int i = 20; i <= 22; i++) drive(1, fr(i), 0, 0, 0);
    drive(1, fr(23), 0, 1, 0);
    chk("skipw_level", level, 1);
    chk("skipw_q", q, fr(23));
`ifdef YUV_FRAME_QUEUE_STATS_EN
    chk("skipw_dropped", dropped_cnt, 3);
`endif
    drive(0, '0, 1, 0, 0);
    chk("skipw_pop_level", level, 0);
    chk("skipw_pop_valid", valid, 0);
    chk("skipw_pop_q", q, fr(23));

    // simultaneous write and pop at level 1
    drive(1, fr(30), 0, 0, 0);
    drive(1, fr(31), 1, 0, 0);
    chk("wp1_q", q, fr(31));
    chk("wp1_valid", valid, 1);
    chk("wp1_level", level, 1);
    drive(0, '0, 1, 0, 0);
    chk("wp1_drain", level, 0);

    // wrap: pointers go round ten times with FIFO order checked at each step
    for (int i = 0; i < 2; i++) begin
      drive(1, fr(200 + i), 0, 0, 0);
      model.push_back(fr(200 + i));
    end
    for (int i = 0; i < 40; i++) begin
      drive(1, fr(300 + i), 0, 0, 0);
      model.push_back(fr(300 + i));
      chk("wrap_wlvl", level, model.size());
      chk("wrap_wq", q, model[0]);
      drive(0, '0, 1, 0, 0);
      void'(model.pop_front());
      chk("wrap_plvl", level, model.size());
      chk("wrap_pq", q, model[0]);
    end

    // asynchronous reset mid-stream
    drive(1, fr(400), 0, 0, 0);
    chk("pre_rst_level", level, 3);
    #3 reset_n = 0;
    #1;
    chk("arst_q", q, 0);
    chk("arst_valid", valid, 0);
    chk("arst_level", level, 0);
    chk("arst_full", full, 0);
    chk("arst_af", almost_full, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_udf", underflow, 0);
`ifdef YUV_FRAME_QUEUE_STATS_EN
    chk("arst_dropped", dropped_cnt, 0);
    chk("arst_repeat", repeat_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
